// File: rtl/hwpe_stream_beat_packer_if.sv
// HWPE-Stream handshake bundle: data with byte strobes, valid/ready flow control.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  valid;
    logic                  ready;

    // Producer side: drives the payload and valid, observes ready.
    modport master (
        output data,
        output strb,
        output valid,
        input  ready
    );

    // Consumer side: observes the payload and valid, drives ready.
    modport slave (
        input  data,
        input  strb,
        input  valid,
        output ready
    );

endinterface

// File: rtl/hwpe_stream_beat_packer.sv
// Collects NB_BEATS narrow stream beats into one wide word (beat 0 in the
// lowest lane). A flush emits a partially filled word whose missing lanes
// carry zero data and zero strobes.
module hwpe_stream_beat_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NB_BEATS   = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              flush_i,
    hwpe_stream_intf_stream.slave             push_i,
    hwpe_stream_intf_stream.master            pop_o,
    output logic [$clog2(NB_BEATS+1)-1:0]     count_o,
    output logic                              flush_pending_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned WIDE_DATA  = DATA_WIDTH * NB_BEATS;
    localparam int unsigned WIDE_STRB  = STRB_WIDTH * NB_BEATS;
    localparam int unsigned CNT_WIDTH  = $clog2(NB_BEATS + 1);

    logic [WIDE_DATA-1:0] accData_q, accData_d;
    logic [WIDE_STRB-1:0] accStrb_q, accStrb_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 flushPending_q, flushPending_d;
    logic [WIDE_DATA-1:0] outData_q, outData_d;
    logic [WIDE_STRB-1:0] outStrb_q, outStrb_d;
    logic                 outValid_q, outValid_d;

    logic [WIDE_DATA-1:0] accWrData;
    logic [WIDE_STRB-1:0] accWrStrb;
    logic outFree;
    logic isLast;
    logic pushReady;
    logic pushHandshake;
    logic wordDone;
    logic flushAccept;
    logic flushLoad;
    logic loadOut;

    // The output register can take a new word when empty or being drained.
    assign outFree       = !outValid_q | pop_o.ready;
    assign isLast        = (cnt_q == CNT_WIDTH'(NB_BEATS - 1));
    // Only the word-completing beat needs room downstream; a pending flush
    // freezes the input so the partial word cannot grow after acceptance.
    assign pushReady     = !flushPending_q & (!isLast | outFree);
    assign pushHandshake = push_i.valid & pushReady;
    assign wordDone      = pushHandshake & isLast;
    // A flush only matters if at least one beat will be held after this cycle
    // and the word is not already completing on its own.
    assign flushAccept   = flush_i & !flushPending_q & !wordDone &
                           ((cnt_q != '0) | pushHandshake);
    assign flushLoad     = (flushAccept | flushPending_q) & outFree;
    assign loadOut       = wordDone | flushLoad;

    assign push_i.ready    = pushReady;
    assign pop_o.data      = outData_q;
    assign pop_o.strb      = outStrb_q;
    assign pop_o.valid     = outValid_q;
    assign count_o         = cnt_q;
    assign flush_pending_o = flushPending_q;

    // Next-state: merge the incoming beat into its lane, then either hand the
    // merged word to the output register or keep accumulating.
    always_comb begin
        accWrData = accData_q;
        accWrStrb = accStrb_q;
        for (int k = 0; k < NB_BEATS; k++) begin
            if (pushHandshake && (cnt_q == CNT_WIDTH'(k))) begin
                accWrData[k*DATA_WIDTH +: DATA_WIDTH] = push_i.data;
                accWrStrb[k*STRB_WIDTH +: STRB_WIDTH] = push_i.strb;
            end
        end

        outData_d      = outData_q;
        outStrb_d      = outStrb_q;
        outValid_d     = outValid_q;
        accData_d      = accWrData;
        accStrb_d      = accWrStrb;
        cnt_d          = cnt_q + CNT_WIDTH'(pushHandshake);
        flushPending_d = (flushAccept | flushPending_q) & !outFree;

        if (loadOut) begin
            outData_d  = accWrData;
            outStrb_d  = accWrStrb;
            outValid_d = 1'b1;
            accData_d  = '0;
            accStrb_d  = '0;
            cnt_d      = '0;
        end else if (pop_o.ready) begin
            outValid_d = 1'b0;
        end
    end

    // State registers; reset and soft clear both drop every held beat and word.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            accData_q      <= '0;
            accStrb_q      <= '0;
            cnt_q          <= '0;
            flushPending_q <= 1'b0;
            outData_q      <= '0;
            outStrb_q      <= '0;
            outValid_q     <= 1'b0;
        end else begin
            accData_q      <= accData_d;
            accStrb_q      <= accStrb_d;
            cnt_q          <= cnt_d;
            flushPending_q <= flushPending_d;
            outData_q      <= outData_d;
            outStrb_q      <= outStrb_d;
            outValid_q     <= outValid_d;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_beat_packer.sv
// Testbench for hwpe_stream_beat_packer: directed scenarios plus a random run,
// all compared against a queue-based reference model of the packing rules.
module tb_hwpe_stream_beat_packer;

    localparam int DW = 32;
    localparam int NB = 4;
    localparam int SW = DW / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int VW = 1 + DW*NB + SW*NB + CW + 1;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          flush;
    logic [CW-1:0] count;
    logic          flushPend;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW))      pushIf ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW*NB))   popIf ();

    hwpe_stream_beat_packer #(.DATA_WIDTH(DW), .NB_BEATS(NB)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clear_i         (clear),
        .flush_i         (flush),
        .push_i          (pushIf.slave),
        .pop_o           (popIf.master),
        .count_o         (count),
        .flush_pending_o (flushPend)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: beats held so far, pending-flush flag, output word.
    logic [DW-1:0]    beatD[$];
    logic [SW-1:0]    beatS[$];
    logic             mPend;
    logic             mValid;
    logic [DW*NB-1:0] mData;
    logic [SW*NB-1:0] mStrb;
    logic [DW*NB-1:0] savedData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic expReady();
        return !mPend && ((beatD.size() < NB - 1) || !mValid || popIf.ready);
    endfunction

    function automatic logic [VW-1:0] dutVec();
        return {popIf.valid, popIf.data, popIf.strb, count, flushPend};
    endfunction

    function automatic logic [VW-1:0] expVec();
        return {mValid, mData, mStrb, CW'(beatD.size()), mPend};
    endfunction

    task automatic applyStimulus(input logic pv, input logic [DW-1:0] d, input logic [SW-1:0] s,
                                 input logic fl, input logic pr, input logic cl);
        pushIf.valid = pv;
        pushIf.data  = d;
        pushIf.strb  = s;
        flush        = fl;
        popIf.ready  = pr;
        clear        = cl;
        #2;
    endtask

    // Advance one clock and apply the packing rules to the model.
    task automatic advance();
        logic hs, load, free;
        @(posedge clk);
        if (rst || clear) begin
            beatD.delete(); beatS.delete();
            mPend = 0; mValid = 0; mData = '0; mStrb = '0;
        end else begin
            hs   = pushIf.valid && expReady();
            free = !mValid || popIf.ready;
            load = 0;
            if (mValid && popIf.ready) mValid = 0;
            if (hs) begin
                beatD.push_back(pushIf.data);
                beatS.push_back(pushIf.strb);
            end
            if (hs && beatD.size() == NB) load = 1;
            else if (flush && !mPend && beatD.size() > 0) mPend = 1;
            if (!load && mPend && free) begin
                load  = 1;
                mPend = 0;
            end
            if (load) begin
                mData = '0;
                mStrb = '0;
                foreach (beatD[i]) begin
                    mData[i*DW +: DW] = beatD[i];
                    mStrb[i*SW +: SW] = beatS[i];
                end
                mValid = 1;
                beatD.delete(); beatS.delete();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        applyStimulus(1, 32'hDEAD_BEEF, 4'hF, 1, 1, 0);
        advance();
        rst = 0;
        checks++;
        if (dutVec() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", dutVec());
        end
        applyStimulus(0, '0, '0, 0, 1, 0);
        checks++;
        if (pushIf.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", pushIf.ready);
        end
        advance();
    endtask

    task automatic test_basic_pack();
        for (int i = 0; i < NB; i++) begin
            applyStimulus(1, DW'(32'h11 * (i + 1)), 4'hF, 0, 1, 0);
            checks++;
            if (pushIf.ready !== expReady()) begin
                errors++;
                $display("[TB] FAIL basic_ready: got %b expected %b", pushIf.ready, expReady());
            end
            advance();
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL basic_model: got %h expected %h", dutVec(), expVec());
            end
        end
        checks++;
        if ({popIf.valid, popIf.strb, popIf.data} !==
            {1'b1, 16'hFFFF, 128'h00000044_00000033_00000022_00000011}) begin
            errors++;
            $display("[TB] FAIL basic_word: got %b %h %h expected 1 ffff 00000044000000330000002200000011",
                     popIf.valid, popIf.strb, popIf.data);
        end
        applyStimulus(0, '0, '0, 0, 1, 0);
        advance();
        checks++;
        if (popIf.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_single_pulse: got valid %b expected 0", popIf.valid);
        end
    endtask

    task automatic test_streaming();
        int words = 0;
        for (int i = 0; i < 3*NB; i++) begin
            applyStimulus(1, $urandom, 4'hF, 0, 1, 0);
            checks++;
            if (pushIf.ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_ready: got %b expected 1 at beat %0d", pushIf.ready, i);
            end
            advance();
            if (popIf.valid === 1'b1) words++;
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL stream_model: got %h expected %h", dutVec(), expVec());
            end
        end
        checks++;
        if (words != 3) begin
            errors++;
            $display("[TB] FAIL stream_words: got %0d expected 3", words);
        end
        applyStimulus(0, '0, '0, 0, 1, 0);
        advance();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 2*NB; i++) begin
            applyStimulus(1, $urandom, 4'hF, 0, (i < NB) ? 1'b1 : 1'b0, 0);
            if (i == NB - 1) savedData = mData;
            if (i == 2*NB - 1) begin
                checks++;
                if ({count, pushIf.ready} !== {CW'(3), 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL bp_stall: got count %0d ready %b expected 3 0", count, pushIf.ready);
                end
            end
            checks++;
            if (pushIf.ready !== expReady()) begin
                errors++;
                $display("[TB] FAIL bp_ready: got %b expected %b", pushIf.ready, expReady());
            end
            advance();
            if (i == NB - 1) savedData = popIf.data === mData ? mData : savedData;
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL bp_model: got %h expected %h", dutVec(), expVec());
            end
        end
        checks++;
        if ({popIf.valid, popIf.data} !== {1'b1, mData}) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %b %h expected 1 %h", popIf.valid, popIf.data, mData);
        end
        applyStimulus(1, 32'hCAFE_0004, 4'hF, 0, 1, 0);
        checks++;
        if (pushIf.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b expected 1", pushIf.ready);
        end
        advance();
        checks++;
        if (dutVec() !== expVec() || popIf.data[DW*NB-1 -: DW] !== 32'hCAFE_0004) begin
            errors++;
            $display("[TB] FAIL bp_new_word: got %h expected %h", dutVec(), expVec());
        end
        applyStimulus(0, '0, '0, 0, 1, 0);
        advance();
    endtask

    task automatic test_flush_partial();
        applyStimulus(1, 32'hA, 4'hF, 0, 1, 0);
        advance();
        applyStimulus(1, 32'hB, 4'hF, 0, 1, 0);
        advance();
        applyStimulus(0, '0, '0, 1, 1, 0);
        advance();
        checks++;
        if ({popIf.valid, popIf.strb, popIf.data, count} !==
            {1'b1, 16'h00FF, 128'h0000000B_0000000A, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL flush_partial: got %b %h %h %0d expected 1 00ff ...0000000b0000000a 0",
                     popIf.valid, popIf.strb, popIf.data, count);
        end
        applyStimulus(0, '0, '0, 0, 1, 0);
        advance();
        applyStimulus(0, '0, '0, 1, 1, 0);
        advance();
        checks++;
        if ({popIf.valid, flushPend} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_empty: got valid %b pending %b expected 0 0", popIf.valid, flushPend);
        end
    endtask

    task automatic test_flush_stall();
        for (int i = 0; i < NB; i++) begin
            applyStimulus(1, $urandom, 4'hF, 0, 1, 0);
            advance();
        end
        applyStimulus(1, 32'h0000_0055, 4'hF, 0, 0, 0);
        advance();
        applyStimulus(0, '0, '0, 1, 0, 0);
        advance();
        applyStimulus(1, 32'h0000_0066, 4'hF, 0, 0, 0);
        checks++;
        if ({flushPend, pushIf.ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL stall_pending: got pending %b ready %b expected 1 0", flushPend, pushIf.ready);
        end
        advance();
        applyStimulus(1, 32'h0000_0077, 4'hF, 0, 1, 0);
        checks++;
        if (pushIf.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_ready_release: got %b expected 0", pushIf.ready);
        end
        advance();
        checks++;
        if ({popIf.valid, popIf.strb, popIf.data, flushPend, count} !==
            {1'b1, 16'h000F, 128'h55, 1'b0, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL stall_word: got %b %h %h %b %0d expected 1 000f ...55 0 0",
                     popIf.valid, popIf.strb, popIf.data, flushPend, count);
        end
        applyStimulus(0, '0, '0, 0, 1, 0);
        advance();
    endtask

    task automatic test_clear_mid_word();
        for (int i = 0; i < 2*NB - 1; i++) begin
            applyStimulus(1, $urandom, 4'hF, 0, (i < NB) ? 1'b1 : 1'b0, 0);
            advance();
        end
        applyStimulus(0, '0, '0, 0, 0, 1);
        advance();
        checks++;
        if ({popIf.valid, count, flushPend} !== '0) begin
            errors++;
            $display("[TB] FAIL clear_state: got valid %b count %0d pending %b expected 0 0 0",
                     popIf.valid, count, flushPend);
        end
        for (int i = 0; i < NB; i++) begin
            applyStimulus(1, DW'(32'hC0 + i), 4'hF, 0, 1, 0);
            advance();
        end
        checks++;
        if ({popIf.valid, popIf.strb, popIf.data} !==
            {1'b1, 16'hFFFF, 128'h000000C3_000000C2_000000C1_000000C0}) begin
            errors++;
            $display("[TB] FAIL clear_clean_word: got %b %h %h", popIf.valid, popIf.strb, popIf.data);
        end
        applyStimulus(0, '0, '0, 0, 1, 0);
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, SW'($urandom),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 63) == 0);
            checks++;
            if (pushIf.ready !== expReady()) begin
                errors++;
                $display("[TB] FAIL random_ready: cycle %0d got %b expected %b", i, pushIf.ready, expReady());
            end
            advance();
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL random_model: cycle %0d got %h expected %h", i, dutVec(), expVec());
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1; clear = 0; flush = 0;
        pushIf.valid = 0; pushIf.data = '0; pushIf.strb = '0; popIf.ready = 1;
        mPend = 0; mValid = 0; mData = '0; mStrb = '0; savedData = '0;
        test_reset();
        test_basic_pack();
        test_streaming();
        test_backpressure();
        test_flush_partial();
        test_flush_stall();
        test_clear_mid_word();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
